// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM command decoder: FSM states, header layout, reset defaults.
// Used by pwm_cmd_ctrl and pwm_ch_regs (optional shadow build: PWM_CTRL_SHADOW_EN).
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LO      = 2'd1,
    HI      = 2'd2,
    DISCARD = 2'd3
  } state_e;

  localparam int CH_LSB   = 0;
  localparam int CH_W     = 4;
  localparam int SEL_BIT  = 4;
  localparam int WR_BIT   = 5;
  localparam int RSVD_MSB = 7;
  localparam int RSVD_LSB = 6;

  localparam logic [15:0] FREQ_RST_DEFAULT = 16'd400;
  localparam logic [15:0] DUTY_RST_DEFAULT = 16'd0;

  function automatic logic [15:0] pick_word(input logic sel, input logic [15:0] freq,
                                            input logic [15:0] duty);
    return sel ? duty : freq;
  endfunction

endpackage

// File: rtl/pwm_ch_regs.sv
// One PWM channel's freq/duty register pair with 16-bit atomic commit.
// With PWM_CTRL_SHADOW_EN defined, writes land in shadows copied to actives on period_start.
module pwm_ch_regs
  import pwm_ctrl_pkg::*;
#(
  parameter logic [15:0] FREQ_RST = FREQ_RST_DEFAULT,
  parameter logic [15:0] DUTY_RST = DUTY_RST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [15:0] wr_data,
  input  logic        period_start,
  output logic [15:0] freq_act,
  output logic [15:0] duty_act,
  output logic [15:0] freq_rd,
  output logic [15:0] duty_rd
);

  logic [15:0] freq_q, freq_d;
  logic [15:0] duty_q, duty_d;

`ifdef PWM_CTRL_SHADOW_EN
  logic [15:0] freq_sh_q, freq_sh_d;
  logic [15:0] duty_sh_q, duty_sh_d;

  // Actives load the pre-commit shadow, so a coinciding commit waits one period.
  always_comb begin
    freq_sh_d = freq_sh_q;
    duty_sh_d = duty_sh_q;
    if (wr_en) begin
      if (wr_sel) duty_sh_d = wr_data;
      else        freq_sh_d = wr_data;
    end
    freq_d = freq_q;
    duty_d = duty_q;
    if (period_start) begin
      freq_d = freq_sh_q;
      duty_d = duty_sh_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_sh_q <= FREQ_RST;
      duty_sh_q <= DUTY_RST;
    end else begin
      freq_sh_q <= freq_sh_d;
      duty_sh_q <= duty_sh_d;
    end
  end

  assign freq_rd = freq_sh_q;
  assign duty_rd = duty_sh_q;
`else
  logic unused_period_start;
  assign unused_period_start = period_start;

  always_comb begin
    freq_d = freq_q;
    duty_d = duty_q;
    if (wr_en) begin
      if (wr_sel) duty_d = wr_data;
      else        freq_d = wr_data;
    end
  end

  assign freq_rd = freq_q;
  assign duty_rd = duty_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q <= FREQ_RST;
      duty_q <= DUTY_RST;
    end else begin
      freq_q <= freq_d;
      duty_q <= duty_d;
    end
  end

  assign freq_act = freq_q;
  assign duty_act = duty_q;

endmodule

// File: rtl/pwm_cmd_ctrl.sv
// SPI command decoder and register bank for NUM_CH PWM channels, burst read/write with wrap.
// Define PWM_CTRL_SHADOW_EN to double-buffer registers and update on period boundaries.
module pwm_cmd_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter logic [15:0] FREQ_RST = FREQ_RST_DEFAULT,
  parameter logic [15:0] DUTY_RST = DUTY_RST_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ss,
  input  logic                   rx_byte_available,
  input  logic [7:0]             rx_byte,
  output logic [7:0]             tx_byte,
  output logic [16*NUM_CH-1:0]   freq_bus,
  output logic [16*NUM_CH-1:0]   duty_bus,
  input  logic [NUM_CH-1:0]      period_start,
  output logic                   cmd_err
);

  localparam logic [4:0]      NUM_CH_V = 5'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d, ch_nxt, rd_ch, hdr_ch;
  logic              sel_q, sel_d, wr_q, wr_d, rd_sel;
  logic [7:0]        lo_buf_q, lo_buf_d;
  logic [7:0]        tx_q, tx_d;
  logic              cmd_err_q, cmd_err_d;
  logic              rxa_prev_q;
  logic              byte_ev, hdr_ok;
  logic [15:0]       rd_word, wr_data;
  logic [NUM_CH-1:0] wr_en;
  logic [15:0]       freq_rd [NUM_CH];
  logic [15:0]       duty_rd [NUM_CH];

  assign byte_ev = rx_byte_available & ~rxa_prev_q;
  assign hdr_ch  = rx_byte[CH_LSB +: CH_W];
  assign hdr_ok  = (rx_byte[RSVD_MSB:RSVD_LSB] == 2'b00) && ({1'b0, hdr_ch} < NUM_CH_V);
  assign ch_nxt  = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
  assign wr_data = {rx_byte, lo_buf_q};

  // Readback source depends on which byte the next event will request.
  always_comb begin
    rd_ch  = ch_q;
    rd_sel = sel_q;
    case (state_q)
      IDLE: begin
        rd_ch  = hdr_ch;
        rd_sel = rx_byte[SEL_BIT];
      end
      HI:      rd_ch = ch_nxt;
      default: ;
    endcase
    rd_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_ch == CH_W'(k)) rd_word = pick_word(rd_sel, freq_rd[k], duty_rd[k]);
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    sel_d     = sel_q;
    wr_d      = wr_q;
    lo_buf_d  = lo_buf_q;
    tx_d      = tx_q;
    cmd_err_d = 1'b0;
    wr_en     = '0;
    if (ss) begin
      state_d = IDLE;
    end else if (byte_ev) begin
      case (state_q)
        IDLE: begin
          if (hdr_ok) begin
            ch_d    = hdr_ch;
            sel_d   = rx_byte[SEL_BIT];
            wr_d    = rx_byte[WR_BIT];
            state_d = LO;
            if (!rx_byte[WR_BIT]) tx_d = rd_word[7:0];
          end else begin
            cmd_err_d = 1'b1;
            state_d   = DISCARD;
          end
        end
        LO: begin
          if (wr_q) lo_buf_d = rx_byte;
          else      tx_d     = rd_word[15:8];
          state_d = HI;
        end
        HI: begin
          for (int k = 0; k < NUM_CH; k++) begin
            wr_en[k] = wr_q && (ch_q == CH_W'(k));
          end
          if (!wr_q) tx_d = rd_word[7:0];
          ch_d    = ch_nxt;
          state_d = LO;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      sel_q      <= 1'b0;
      wr_q       <= 1'b0;
      lo_buf_q   <= '0;
      tx_q       <= '0;
      cmd_err_q  <= 1'b0;
      rxa_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      sel_q      <= sel_d;
      wr_q       <= wr_d;
      lo_buf_q   <= lo_buf_d;
      tx_q       <= tx_d;
      cmd_err_q  <= cmd_err_d;
      rxa_prev_q <= rx_byte_available;
    end
  end

  assign tx_byte = tx_q;
  assign cmd_err = cmd_err_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_ch_regs #(
      .FREQ_RST (FREQ_RST),
      .DUTY_RST (DUTY_RST)
    ) u_regs (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en[k]),
      .wr_sel       (sel_q),
      .wr_data      (wr_data),
      .period_start (period_start[k]),
      .freq_act     (freq_bus[16*k +: 16]),
      .duty_act     (duty_bus[16*k +: 16]),
      .freq_rd      (freq_rd[k]),
      .duty_rd      (duty_rd[k])
    );
  end

endmodule

// File: tb/tb_pwm_cmd_ctrl.sv
// Scoreboard bench for pwm_cmd_ctrl: transaction-level model predicts tx/bus/err per byte event.
module tb_pwm_cmd_ctrl;
  localparam int NUM_CH = 4;
  localparam int BW     = 16 * NUM_CH;
  localparam logic [15:0] F_RST = 16'd400;
  localparam logic [15:0] D_RST = 16'd0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ss = 1'b1;
  logic              rxa = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic [7:0]        tx_byte;
  logic [BW-1:0]     freq_bus, duty_bus;
  logic [NUM_CH-1:0] period_start = '0;
  logic              cmd_err;

  always #5 clk = ~clk;

  pwm_cmd_ctrl #(.NUM_CH(NUM_CH), .FREQ_RST(F_RST), .DUTY_RST(D_RST)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ss                (ss),
    .rx_byte_available (rxa),
    .rx_byte           (rx_byte),
    .tx_byte           (tx_byte),
    .freq_bus          (freq_bus),
    .duty_bus          (duty_bus),
    .period_start      (period_start),
    .cmd_err           (cmd_err)
  );

  typedef struct packed {
    logic [7:0]    tx;
    logic [BW-1:0] fb;
    logic [BW-1:0] db;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: per-channel registers plus transaction position tracking.
  logic [15:0] sh_f [NUM_CH];
  logic [15:0] sh_d [NUM_CH];
  logic [15:0] ac_f [NUM_CH];
  logic [15:0] ac_d [NUM_CH];
  int          m_idx, m_start;
  logic        m_sel, m_wr, m_bad;
  logic [7:0]  m_buf, m_tx;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rd(input int ch);
    return m_sel ? sh_d[ch] : sh_f[ch];
  endfunction

  function automatic logic [BW-1:0] bus(input logic duty);
    logic [BW-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[16*k +: 16] = duty ? ac_d[k] : ac_f[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      sh_f[k] = F_RST; sh_d[k] = D_RST; ac_f[k] = F_RST; ac_d[k] = D_RST;
    end
    m_tx = 8'h00; m_idx = 0; m_bad = 1'b0; m_buf = 8'h00;
  endtask

  task automatic model_write(input int ch, input logic [15:0] v);
    if (m_sel) sh_d[ch] = v; else sh_f[ch] = v;
`ifndef PWM_CTRL_SHADOW_EN
    ac_f[ch] = sh_f[ch];
    ac_d[ch] = sh_d[ch];
`endif
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    exp_t e;
    int pos, ch;
    logic [15:0] w;
    e.err = 1'b0;
    if (m_idx == 0) begin
      if (b[7:6] != 2'b00 || int'(b[3:0]) >= NUM_CH) begin
        m_bad = 1'b1;
        e.err = 1'b1;
      end else begin
        m_start = int'(b[3:0]);
        m_sel = b[4];
        m_wr = b[5];
        if (!m_wr) begin w = rd(m_start); m_tx = w[7:0]; end
      end
    end else if (!m_bad) begin
      pos = m_idx - 1;
      ch = (m_start + pos / 2) % NUM_CH;
      if (pos % 2 == 0) begin
        if (m_wr) m_buf = b;
        else begin w = rd(ch); m_tx = w[15:8]; end
      end else begin
        if (m_wr) model_write(ch, {b, m_buf});
        else begin w = rd((ch + 1) % NUM_CH); m_tx = w[7:0]; end
      end
    end
    m_idx++;
    e.tx = m_tx;
    e.fb = bus(1'b0);
    e.db = bus(1'b1);
    sb_q.push_back(e);
    @(negedge clk);
    rx_byte = b;
    rxa = 1'b1;
    repeat (hold) @(negedge clk);
    rxa = 1'b0;
  endtask

  task automatic ss_begin();
    @(negedge clk);
    ss = 1'b0;
    m_idx = 0;
    m_bad = 1'b0;
  endtask

  task automatic ss_end();
    @(negedge clk);
    ss = 1'b1;
    @(negedge clk);
    period_start = '1;
    @(negedge clk);
    period_start = '0;
`ifdef PWM_CTRL_SHADOW_EN
    for (int k = 0; k < NUM_CH; k++) begin ac_f[k] = sh_f[k]; ac_d[k] = sh_d[k]; end
`endif
  endtask

  // Monitor: one expected record per byte event seen while ss is low.
  initial begin : monitor
    logic prev;
    logic ev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      ev = rst_n && !ss && rxa && !prev;
      prev = rst_n ? rxa : 1'b0;
      if (ev) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got tx=%h expected no event", tx_byte);
        end else begin
          e = sb_q.pop_front();
          check("tx_byte", BW'(tx_byte), BW'(e.tx));
          check("freq_bus", freq_bus, e.fb);
          check("duty_bus", duty_bus, e.db);
          check("cmd_err", BW'(cmd_err), BW'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] h;
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_tx", BW'(tx_byte), '0);
    check("rst_err", BW'(cmd_err), '0);
    check("rst_freq", freq_bus, {NUM_CH{F_RST}});
    check("rst_duty", duty_bus, {NUM_CH{D_RST}});
    rst_n = 1'b1;

    // Write freq ch0 = 0x0190
    ss_begin(); send(8'h20, 1); send(8'h90, 1); send(8'h01, 1); ss_end();
    check("wr_freq_ch0", BW'(freq_bus[15:0]), BW'(16'h0190));

    // Burst duty from ch3 with wrap
    ss_begin();
    send(8'h33, 1);
    send(8'h0A, 1); send(8'h00, 1);
    send(8'h0B, 1); send(8'h00, 1);
    send(8'h0C, 1); send(8'h00, 1);
    ss_end();
    check("duty_ch3", BW'(duty_bus[63:48]), BW'(16'h000A));
    check("duty_ch0", BW'(duty_bus[15:0]), BW'(16'h000B));
    check("duty_ch1", BW'(duty_bus[31:16]), BW'(16'h000C));
    check("duty_ch2", BW'(duty_bus[47:32]), BW'(D_RST));

    // Read freq ch1, one dummy byte held for 10 cycles
    ss_begin(); send(8'h01, 1); send(8'hFF, 10); send(8'hFF, 1); ss_end();

    // Abort mid-pair, then read freq ch2
    ss_begin(); send(8'h22, 1); send(8'h55, 1); ss_end();
    ss_begin(); send(8'h02, 1); ss_end();
    check("abort_freq_ch2", BW'(freq_bus[47:32]), BW'(F_RST));
    check("abort_tx", BW'(tx_byte), BW'(8'h90));

    // Invalid headers: reserved bit, then channel out of range
    ss_begin(); send(8'h45, 1); send(8'h12, 1); send(8'h34, 10); send(8'h56, 1); ss_end();
    ss_begin(); send(8'h25, 1); send(8'h78, 1); send(8'h9A, 1); ss_end();

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0)
        h = ($urandom_range(0, 1) == 1) ? (8'h40 | 8'($urandom_range(0, 63)))
                                        : {2'b00, 2'($urandom_range(0, 3)), 4'($urandom_range(NUM_CH, 15))};
      else
        h = {2'b00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, NUM_CH - 1))};
      n = $urandom_range(1, 11);
      ss_begin();
      send(h, 1);
      for (int i = 0; i < n; i++) send(8'($urandom), $urandom_range(1, 3));
      ss_end();
    end

    // Async reset mid-burst, off the clock edge
    ss_begin(); send(8'h31, 1); send(8'h77, 1); send(8'h66, 1); send(8'h12, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_tx", BW'(tx_byte), '0);
    check("async_err", BW'(cmd_err), '0);
    check("async_freq", freq_bus, {NUM_CH{F_RST}});
    check("async_duty", duty_bus, {NUM_CH{D_RST}});
    model_reset();
    ss = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    ss_begin(); send(8'h03, 1); send(8'h00, 1); ss_end();

    repeat (4) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_cmd_ctrl.md
Name: pwm_cmd_ctrl

Overview:
SPI command decoder and register bank for NUM_CH PWM channels. It sits between spi_slave and an array of pwm instances. It parses command bytes from the SPI receive stream and owns each channel's 16-bit freq and duty_cycle_usec registers. It supports multi-channel burst read/write with channel auto-increment and loads tx_byte for readback.

Parameters:
NUM_CH, 4, number of PWM channels; 1..16
FREQ_RST, 400, reset value of every channel's freq register
DUTY_RST, 0, reset value of every channel's duty register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ss  in  1  SPI slave select, active low; high aborts any transaction
rx_byte_available  in  1  level from spi_slave; a rising edge marks a new byte
rx_byte  in  8  received byte, valid when rx_byte_available is high
tx_byte  out  8  next byte for spi_slave to shift out
freq_bus  out  16*NUM_CH  active freq per channel, channel k at [16k +: 16]
duty_bus  out  16*NUM_CH  active duty_cycle_usec per channel, same packing
period_start  in  NUM_CH  one-cycle pulse per channel at its PWM period boundary
cmd_err  out  1  one-cycle pulse when a header is rejected

Behaviour:
- Reset (async assert, sync release): all freq = FREQ_RST, all duty = DUTY_RST, shadows equal to actives, tx_byte = 0, cmd_err = 0, state = IDLE.
- Byte event: rx_byte_available high while its registered previous value is low. Events are processed only while ss = 0. A level held high for many cycles is exactly one event.
- ss = 1 forces state IDLE on the next clk, regardless of any simultaneous event. A LO byte already buffered is discarded and no register changes.
- Header byte: [3:0] start channel ch, [4] sel (1 = duty, 0 = freq), [5] wr (1 = write, 0 = read), [7:6] reserved.
- States and transitions:
  - IDLE, header event, valid (reserved = 0, ch < NUM_CH): latch ch/sel/wr, go to LO. On a read, tx_byte <= reg[ch][7:0] in the same cycle.
  - IDLE, header event, invalid: pulse cmd_err, go to DISCARD.
  - LO, event: on a write, buffer rx_byte; on a read, tx_byte <= reg[ch][15:8]. Go to HI.
  - HI, event: on a write, commit {rx_byte, buffer} to reg[ch]. Then ch <= (ch == NUM_CH-1) ? 0 : ch+1 and go to LO. On a read, tx_byte <= reg[next ch][7:0].
  - DISCARD: ignore all events until ss = 1.
- reg[] means shadow when PWM_CTRL_SHADOW_EN is defined, otherwise the active register. The 16-bit commit is atomic: the high byte is never visible without its low byte.
- Latency: a commit appears on freq_bus/duty_bus 1 clk after the HI event (non-shadow). tx_byte updates 1 clk after each event.
- Burst wraps from channel NUM_CH-1 to 0 indefinitely.

Optional Feature:
PWM_CTRL_SHADOW_EN
- Defined: writes go to per-channel shadow registers. The active register copies its shadow on that channel's period_start pulse. If a commit and period_start coincide on a channel, the active register takes the pre-commit shadow and the new value takes effect at the next boundary. Readback returns the shadow. No partial-period glitches.
- Undefined: writes go straight to the active registers, period_start is ignored, and no shadow flops are built.

Decomposition:
- Package pwm_ctrl_pkg:
  - State encoding (IDLE, LO, HI, DISCARD).
  - Header bit positions (CH_LSB = 0, CH_W = 4, SEL_BIT = 4, WR_BIT = 5, RSVD_MSB = 7).
  - Default constants FREQ_RST and DUTY_RST.
- Sub-module pwm_ch_regs: one channel's freq/duty active and shadow pair with commit and period_start load. Instantiated NUM_CH times via generate.

Test Plan:
- Write freq ch0: ss low, bytes 0x20, 0x90, 0x01 -> freq_bus[15:0] = 0x0190 (shadow: after a period_start[0] pulse). Other channels unchanged.
- Burst write duty, NUM_CH = 4: header 0x33, then pairs 0x0A00, 0x0B00, 0x0C00 LSB first -> duty ch3 = 0x000A, ch0 = 0x000B, ch1 = 0x000C (wrap verified).
- Read freq ch1 after reset: header 0x01, then dummy bytes -> tx_byte sequence 0x90, 0x01, then ch2 low byte 0x90.
- Abort mid-pair: header 0x22, byte 0x55, ss high, then new transaction header 0x02 -> ch2 freq still 400 and tx_byte = 0x90.
- Invalid header 0x45 (reserved bit set), or ch = 5 with NUM_CH = 4 -> cmd_err pulses once and all following bytes are ignored until ss rises. Holding rx_byte_available high for 10 cycles produces exactly one event.
- Async reset mid-burst (rst_n low off a clk edge) -> outputs immediately at reset values; the first header after release is decoded normally.
